// File: rtl/jtag_user_pkg.sv
// jtag_user_pkg: shared types and field layout for the jtaglet
// user-DR command scheduler and its channel bridges.
package jtag_user_pkg;

    typedef enum logic [1:0] {
        CMD_NOP    = 2'b00,
        CMD_WRITE  = 2'b01,
        CMD_READ   = 2'b10,
        CMD_STATUS = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR_WAIT,
        ST_RD_WAIT,
        ST_DONE
    } state_e;

    localparam int STS_BADCH   = 0;
    localparam int STS_OVERRUN = 1;
    localparam int STS_TIMEOUT = 2;

    localparam int CMD_MSB   = 31;
    localparam int CH_LSB    = 28;
    localparam int PAYLOAD_W = 28;

    localparam logic [1:0]  TAG_WR_ACK  = 2'b01;
    localparam logic [1:0]  TAG_RD_DATA = 2'b10;
    localparam logic [1:0]  TAG_TIMEOUT = 2'b11;
    localparam logic [15:0] TAG_BADCH   = 16'hBAD0;

    function automatic logic [31:0] resp_word(
        input logic [1:0]           tag,
        input logic [1:0]           ch,
        input logic [PAYLOAD_W-1:0] body
    );
        return {tag, ch, body};
    endfunction

endpackage

// File: rtl/jtag_user_timeout.sv
// jtag_user_timeout: loadable down-counter; expire is high on the
// last counted cycle so the owner can abort on that edge.
module jtag_user_timeout #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         run,
    output logic         expire
);

    logic [W-1:0] count;

    // Clear wins over load; count down only while running and non-zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (run && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign expire = (count == W'(1));

endmodule

// File: rtl/jtag_user_sched.sv
// jtag_user_sched: decodes user-DR words into channel write/read
// requests on tck and returns ack, data or status on next capture.
module jtag_user_sched
    import jtag_user_pkg::*;
#(
    parameter int          G_NUM_CH     = 4,
    parameter int          G_TIMEOUT    = 255,
    parameter logic [31:0] G_RESET_WORD = 32'hE6712945
) (
    input  logic                     tck,
    input  logic                     trst,
    input  logic                     user_op,
    input  logic [31:0]              user_wdata,
    output logic [31:0]              user_rdata,
    output logic                     user_op_ready,
    output logic [G_NUM_CH-1:0]      ch_wr_valid,
    output logic [27:0]              ch_wr_data,
    input  logic [G_NUM_CH-1:0]      ch_wr_ready,
    output logic [G_NUM_CH-1:0]      ch_rd_req,
    input  logic [G_NUM_CH-1:0]      ch_rd_valid,
    input  logic [28*G_NUM_CH-1:0]   ch_rd_data
);

    state_e                 state;
    logic [1:0]             cur_ch;
    logic [7:0]             status;
    logic [7:0]             status_nxt;

    cmd_e                   cmd;
    logic [1:0]             cmd_ch;
    logic [PAYLOAD_W-1:0]   payload;
    logic                   bad_ch;
    logic                   is_xfer;
    logic [G_NUM_CH-1:0]    cmd_sel;

    logic                   hs_wr;
    logic                   hs_rd;
    logic                   hs;
    logic [PAYLOAD_W-1:0]   rd_word;
    logic                   in_wait;
    logic                   accept;

    logic                   tmo_load;
    logic                   tmo_clear;
    logic                   tmo_expire;

    // Field decode and selection of the active channel's handshake
    always_comb begin
        cmd     = cmd_e'(user_wdata[CMD_MSB -: 2]);
        cmd_ch  = user_wdata[CH_LSB +: 2];
        payload = user_wdata[PAYLOAD_W-1:0];
        bad_ch  = ({1'b0, cmd_ch} >= 3'(G_NUM_CH));
        is_xfer = (cmd == CMD_WRITE) || (cmd == CMD_READ);
        cmd_sel = '0;
        hs_wr   = 1'b0;
        hs_rd   = 1'b0;
        rd_word = '0;
        for (int c = 0; c < G_NUM_CH; c++) begin
            if (cmd_ch == 2'(c)) begin
                cmd_sel[c] = 1'b1;
            end
            if (cur_ch == 2'(c)) begin
                hs_wr   = ch_wr_ready[c];
                hs_rd   = ch_rd_valid[c];
                rd_word = ch_rd_data[28*c +: 28];
            end
        end
    end

    assign in_wait   = (state == ST_WR_WAIT) || (state == ST_RD_WAIT);
    assign hs        = (state == ST_WR_WAIT) ? hs_wr : hs_rd;
    assign accept    = user_op && (state == ST_IDLE);
    assign tmo_load  = accept && is_xfer && !bad_ch;
    assign tmo_clear = in_wait && (hs || tmo_expire);

    // Sticky status: a STATUS read clears, same-edge errors survive
    always_comb begin
        status_nxt = status;
        if (accept && cmd == CMD_STATUS) begin
            status_nxt = '0;
        end
        if (accept && is_xfer && bad_ch) begin
            status_nxt[STS_BADCH] = 1'b1;
        end
        if (user_op && !user_op_ready) begin
            status_nxt[STS_OVERRUN] = 1'b1;
        end
        if (in_wait && !hs && tmo_expire) begin
            status_nxt[STS_TIMEOUT] = 1'b1;
        end
    end

    jtag_user_timeout #(
        .W(8)
    ) u_timeout (
        .clk      (tck),
        .rst_n    (trst),
        .clear    (tmo_clear),
        .load     (tmo_load),
        .load_val (8'(G_TIMEOUT)),
        .run      (in_wait),
        .expire   (tmo_expire)
    );

    // Scheduler FSM with registered channel requests and response word
    always_ff @(posedge tck) begin
        if (!trst) begin
            state         <= ST_IDLE;
            cur_ch        <= '0;
            status        <= '0;
            user_rdata    <= G_RESET_WORD;
            user_op_ready <= 1'b1;
            ch_wr_valid   <= '0;
            ch_wr_data    <= '0;
            ch_rd_req     <= '0;
        end else begin
            status <= status_nxt;
            unique case (state)
                ST_IDLE: begin
                    if (user_op) begin
                        unique case (cmd)
                            CMD_NOP: begin
                            end
                            CMD_STATUS: begin
                                user_rdata <= {status, 8'h00, 14'h0,
                                               2'(G_NUM_CH-1)};
                            end
                            default: begin
                                if (bad_ch) begin
                                    user_rdata <= {TAG_BADCH, 14'h0, cmd_ch};
                                end else begin
                                    cur_ch        <= cmd_ch;
                                    user_op_ready <= 1'b0;
                                    if (cmd == CMD_WRITE) begin
                                        ch_wr_valid <= cmd_sel;
                                        ch_wr_data  <= payload;
                                        state       <= ST_WR_WAIT;
                                    end else begin
                                        ch_rd_req <= cmd_sel;
                                        state     <= ST_RD_WAIT;
                                    end
                                end
                            end
                        endcase
                    end
                end
                ST_WR_WAIT: begin
                    if (hs_wr) begin
                        ch_wr_valid <= '0;
                        user_rdata  <= resp_word(TAG_WR_ACK, cur_ch, '0);
                        state       <= ST_DONE;
                    end else if (tmo_expire) begin
                        ch_wr_valid <= '0;
                        user_rdata  <= resp_word(TAG_TIMEOUT, cur_ch, '0);
                        state       <= ST_DONE;
                    end
                end
                ST_RD_WAIT: begin
                    if (hs_rd) begin
                        ch_rd_req  <= '0;
                        user_rdata <= resp_word(TAG_RD_DATA, cur_ch, rd_word);
                        state      <= ST_DONE;
                    end else if (tmo_expire) begin
                        ch_rd_req  <= '0;
                        user_rdata <= resp_word(TAG_TIMEOUT, cur_ch, '0);
                        state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    user_op_ready <= 1'b1;
                    state         <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_user_sched.sv
// tb_jtag_user_sched: directed vectors against two scheduler
// instances (4 channels / short timeout, and 2 channels).
module tb_jtag_user_sched;

    logic tck = 1'b0;
    always #5 tck = ~tck;

    logic         trst;

    logic         a_op;
    logic [31:0]  a_wdata;
    logic [31:0]  a_rdata;
    logic         a_ready;
    logic [3:0]   a_wr_valid;
    logic [27:0]  a_wr_data;
    logic [3:0]   a_wr_ready;
    logic [3:0]   a_rd_req;
    logic [3:0]   a_rd_valid;
    logic [111:0] a_rd_data;

    logic         b_op;
    logic [31:0]  b_wdata;
    logic [31:0]  b_rdata;
    logic         b_ready;
    logic [1:0]   b_wr_valid;
    logic [27:0]  b_wr_data;
    logic [1:0]   b_wr_ready;
    logic [1:0]   b_rd_req;
    logic [1:0]   b_rd_valid;
    logic [55:0]  b_rd_data;

    int checks   = 0;
    int failures = 0;

    jtag_user_sched #(
        .G_NUM_CH  (4),
        .G_TIMEOUT (8)
    ) dut_a (
        .tck           (tck),
        .trst          (trst),
        .user_op       (a_op),
        .user_wdata    (a_wdata),
        .user_rdata    (a_rdata),
        .user_op_ready (a_ready),
        .ch_wr_valid   (a_wr_valid),
        .ch_wr_data    (a_wr_data),
        .ch_wr_ready   (a_wr_ready),
        .ch_rd_req     (a_rd_req),
        .ch_rd_valid   (a_rd_valid),
        .ch_rd_data    (a_rd_data)
    );

    jtag_user_sched #(
        .G_NUM_CH (2)
    ) dut_b (
        .tck           (tck),
        .trst          (trst),
        .user_op       (b_op),
        .user_wdata    (b_wdata),
        .user_rdata    (b_rdata),
        .user_op_ready (b_ready),
        .ch_wr_valid   (b_wr_valid),
        .ch_wr_data    (b_wr_data),
        .ch_wr_ready   (b_wr_ready),
        .ch_rd_req     (b_rd_req),
        .ch_rd_valid   (b_rd_valid),
        .ch_rd_data    (b_rd_data)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge tck);
        #1;
    endtask

    task automatic opa(input logic [31:0] w);
        a_op    = 1'b1;
        a_wdata = w;
        step();
        a_op    = 1'b0;
    endtask

    task automatic opb(input logic [31:0] w);
        b_op    = 1'b1;
        b_wdata = w;
        step();
        b_op    = 1'b0;
    endtask

    initial begin
        trst       = 1'b0;
        a_op       = 1'b0;
        a_wdata    = '0;
        a_wr_ready = '0;
        a_rd_valid = '0;
        a_rd_data  = {28'h0EEEEEE, 28'h1234567, 28'h0DDDDDD, 28'h0CCCCCC};
        b_op       = 1'b0;
        b_wdata    = '0;
        b_wr_ready = '0;
        b_rd_valid = '0;
        b_rd_data  = {28'h0AAAAAA, 28'h0555555};
        step();
        step();
        trst = 1'b1;

        check("rst_rdata", a_rdata, 32'hE6712945);
        check("rst_ready", a_ready, 1);
        check("rst_wr_valid", a_wr_valid, 0);
        check("rst_rd_req", a_rd_req, 0);
        check("rst_wr_data", a_wr_data, 0);

        // WRITE ch1, ready after 3 cycles; other channels' ready ignored
        opa(32'h50ABCDEF);
        check("wr_valid_e0", a_wr_valid, 4'b0010);
        check("wr_data_e0", a_wr_data, 28'h0ABCDEF);
        check("wr_busy_e0", a_ready, 0);
        a_wr_ready = 4'b1101;
        step();
        check("wr_valid_e1", a_wr_valid, 4'b0010);
        check("wr_hold_rdata", a_rdata, 32'hE6712945);
        step();
        check("wr_valid_e2", a_wr_valid, 4'b0010);
        check("wr_data_e2", a_wr_data, 28'h0ABCDEF);
        a_wr_ready = 4'b0010;
        step();
        a_wr_ready = 4'b0000;
        check("wr_valid_drop", a_wr_valid, 0);
        check("wr_ack", a_rdata, 32'h50000000);
        check("wr_done_busy", a_ready, 0);
        step();
        check("wr_ready_back", a_ready, 1);

        // READ ch2, valid after 5 cycles; ch0 valid ignored
        a_rd_valid = 4'b0001;
        opa(32'hA0000000);
        check("rd_req_e0", a_rd_req, 4'b0100);
        step();
        step();
        step();
        step();
        check("rd_req_e4", a_rd_req, 4'b0100);
        check("rd_hold_rdata", a_rdata, 32'h50000000);
        a_rd_valid = 4'b0100;
        step();
        a_rd_valid = 4'b0000;
        check("rd_data", a_rdata, 32'hA1234567);
        check("rd_req_drop", a_rd_req, 0);
        step();
        check("rd_ready_back", a_ready, 1);

        // READ ch0 never answered -> timeout after 8 cycles
        opa(32'h80000000);
        check("to_req_e0", a_rd_req, 4'b0001);
        for (int i = 0; i < 7; i++) step();
        check("to_req_e7", a_rd_req, 4'b0001);
        check("to_rdata_e7", a_rdata, 32'hA1234567);
        step();
        check("to_req_drop", a_rd_req, 0);
        check("to_rdata", a_rdata, 32'hC0000000);
        step();
        check("to_ready_back", a_ready, 1);
        opa(32'hC0000000);
        check("status_to", a_rdata, 32'h04000003);
        opa(32'hC0000000);
        check("status_clr", a_rdata, 32'h00000003);

        // user_op during WR_WAIT is dropped and flags OVERRUN
        opa(32'h70000055);
        check("ov_valid_e0", a_wr_valid, 4'b1000);
        opa(32'h80000000);
        check("ov_no_rd", a_rd_req, 0);
        check("ov_valid_e1", a_wr_valid, 4'b1000);
        check("ov_data", a_wr_data, 28'h0000055);
        a_wr_ready = 4'b1000;
        step();
        a_wr_ready = 4'b0000;
        check("ov_ack", a_rdata, 32'h70000000);
        step();
        opa(32'hC0000000);
        check("status_ov", a_rdata, 32'h02000003);

        // Handshake on the timeout edge wins
        opa(32'h40000001);
        for (int i = 0; i < 7; i++) step();
        check("hw_valid_e7", a_wr_valid, 4'b0001);
        a_wr_ready = 4'b0001;
        step();
        a_wr_ready = 4'b0000;
        check("hw_ack", a_rdata, 32'h40000000);
        check("hw_valid_drop", a_wr_valid, 0);
        step();
        opa(32'hC0000000);
        check("status_hw", a_rdata, 32'h00000003);

        // Ready tied high: ack 2 edges, ready 3 edges after user_op
        a_wr_ready = 4'b0100;
        opa(32'h60000123);
        check("lat_valid", a_wr_valid, 4'b0100);
        check("lat_data", a_wr_data, 28'h0000123);
        step();
        check("lat_ack", a_rdata, 32'h60000000);
        check("lat_busy", a_ready, 0);
        step();
        check("lat_ready", a_ready, 1);
        a_wr_ready = 4'b0000;

        // NOP leaves everything alone
        opa(32'h00000000);
        check("nop_rdata", a_rdata, 32'h60000000);
        check("nop_ready", a_ready, 1);
        check("nop_valid", a_wr_valid, 0);

        // Two-channel instance: bad channel and reset mid-read
        opb(32'h70000000);
        check("bad_valid", b_wr_valid, 0);
        check("bad_rdata", b_rdata, 32'hBAD00003);
        check("bad_ready", b_ready, 1);
        opb(32'hC0000000);
        check("bad_status", b_rdata, 32'h01000001);
        opb(32'h90000000);
        check("b_rd_req", b_rd_req, 2'b10);
        check("b_busy", b_ready, 0);
        trst = 1'b0;
        step();
        check("rst_mid_req", b_rd_req, 0);
        check("rst_mid_rdata", b_rdata, 32'hE6712945);
        check("rst_mid_ready", b_ready, 1);
        check("rst_a_rdata", a_rdata, 32'hE6712945);
        trst = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jtag_user_sched.md
Name: jtag_user_sched

Overview:
Command scheduler between the jtaglet user data register and up to four on-chip user channels. It decodes each 32-bit word shifted in through the user DR and issues a write or read to the selected channel over valid/ready. It returns read data or status on the next user DR capture. It runs on the TAP clock and throttles the host through user_op_ready.

Parameters:
G_NUM_CH, 4, number of user channels (1..4)
G_TIMEOUT, 255, tck cycles to wait for a channel handshake before abort (1..255)
G_RESET_WORD, 32'hE6712945, user_rdata value after reset (signature word)

Ports:
tck  in  1  TAP clock; all logic on rising edge
trst  in  1  reset, synchronous, active-low
user_op  in  1  one-cycle pulse: jtaglet has completed a user DR update
user_wdata  in  32  word shifted in by the host; valid when user_op=1
user_rdata  out  32  word jtaglet loads at the next user DR capture
user_op_ready  out  1  1 = a new user_op is accepted
ch_wr_valid  out  G_NUM_CH  per-channel write request
ch_wr_data  out  28  write payload, shared by all channels
ch_wr_ready  in  G_NUM_CH  per-channel write accept
ch_rd_req  out  G_NUM_CH  per-channel read request (level)
ch_rd_valid  in  G_NUM_CH  per-channel read data valid
ch_rd_data  in  28*G_NUM_CH  read data, channel c in bits [28c+27:28c]

Behaviour:
- Command decode of user_wdata:
  - [31:30] cmd: 00 NOP, 01 WRITE, 10 READ, 11 STATUS.
  - [29:28] ch.
  - [27:0] payload.
- States: IDLE, WR_WAIT, RD_WAIT, DONE.
- Reset (trst low at a tck edge): state=IDLE, user_rdata=G_RESET_WORD, user_op_ready=1, all ch_* outputs 0, timeout counter=0, status=0.
- IDLE, user_op=1:
  - NOP: no change.
  - STATUS: user_rdata = {status[7:0], 8'h00, 14'h0, G_NUM_CH-1 (2b)}. No state change.
  - WRITE / READ with ch >= G_NUM_CH:
    - status.BADCH (bit0) set.
    - user_rdata = 32'hBAD0_0000 | ch.
    - Stay in IDLE.
  - WRITE, ch valid:
    - Next cycle: ch_wr_valid[ch]=1, ch_wr_data=payload.
    - user_op_ready=0; go to WR_WAIT.
  - READ, ch valid:
    - Next cycle: ch_rd_req[ch]=1.
    - user_op_ready=0; go to RD_WAIT.
- user_op while user_op_ready=0: word dropped, status.OVERRUN (bit1) set, no other effect.
- WR_WAIT:
  - Hold valid and data stable until ch_wr_ready[ch]=1 at a clock edge.
  - On that edge: drop valid, user_rdata = {2'b01, ch, 28'h0} (ack), go to DONE.
- RD_WAIT:
  - Hold ch_rd_req[ch]=1 until ch_rd_valid[ch]=1.
  - On that edge: capture user_rdata = {2'b10, ch, ch_rd_data[ch]}, drop req, go to DONE.
- Timeout in WR_WAIT / RD_WAIT:
  - Counter increments every cycle in the wait state and clears on entry.
  - When counter reaches G_TIMEOUT without a handshake: drop request, status.TIMEOUT (bit2) set, user_rdata = {2'b11, ch, 28'h0}, go to DONE.
  - A handshake on the same edge as the timeout wins; no TIMEOUT is flagged.
- DONE: one cycle, then IDLE with user_op_ready=1.
- Latency: a write to a channel with ready tied high gives user_op → ack in user_rdata in 2 cycles, and user_op_ready high again 3 cycles after user_op.
- Channel handshakes: ready/valid from other channels are ignored; exactly one channel is requested at a time.
- Status:
  - Bits are sticky.
  - A STATUS command returns the bits, then clears them on the same edge.
  - An error occurring on that same edge stays set.
- user_rdata changes only on the edges listed above; otherwise it holds its value.
- Reset mid-transaction: request outputs drop on the reset edge with no handshake completion. Channels must tolerate valid/req withdrawal during reset.

Decomposition:
- Package jtag_user_pkg:
  - cmd enum (NOP/WRITE/READ/STATUS) and state enum.
  - Status bit index constants.
  - Field-position localparams (CMD_MSB=31, CH_LSB=28, PAYLOAD_W=28).
  - Response tag constants.
- Sub-module jtag_user_timeout: loadable down-counter with clear and expire flag, reused by future channel bridges.

Test Plan:
- Reset then capture → user_rdata=32'hE6712945, user_op_ready=1, all ch outputs 0.
- WRITE ch1 payload 28'h0ABCDEF with ch_wr_ready[1] high after 3 cycles → ch_wr_valid[1] held 3 cycles with data 0ABCDEF, then user_rdata=32'h50000000 and ready high 1 cycle later.
- READ ch2 with ch_rd_data[2]=28'h1234567 and rd_valid after 5 cycles → user_rdata=32'hA1234567.
- READ ch0 with rd_valid never asserted, G_TIMEOUT=8 → req dropped after 8 cycles, user_rdata=32'hC0000000; next STATUS → bits[31:24]=8'h04, then a second STATUS → bits[31:24]=8'h00.
- user_op pulse during WR_WAIT → word ignored, OVERRUN set, in-flight write completes normally.
- G_NUM_CH=2, WRITE ch3 → no ch_wr_valid, user_rdata=32'hBAD00003, BADCH set; trst low during RD_WAIT → req low next edge, user_rdata=G_RESET_WORD.
